gray_updown_counter_param: RTL
==============================

Name: gray_updown_counter_param

Overview:
Parametrised Gray-code up/down counter, successor to the fixed 3-bit Gray counter. Adds enable, synchronous load, a programmable terminal value, and a wrap/saturate mode. Adds registered boundary flags and a binary mirror output. Used as a pointer/sequence source wherever single-bit-change count values cross into other logic.

Parameters:
WIDTH, 3, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, highest count value in binary (1..2**WIDTH-1); the count range is 0..MAX_VAL.
RESET_VAL, 0, binary value loaded on reset (must be <= MAX_VAL).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
en  in  1  count enable; one step per clock while high
up_down  in  1  1 = count up, 0 = count down
sat_mode  in  1  1 = saturate at bounds, 0 = wrap around
load  in  1  synchronous load strobe
load_val  in  WIDTH  binary value to load
count_gray  out  WIDTH  registered Gray-coded count
count_bin  out  WIDTH  registered binary count (same cycle as count_gray)
at_max  out  1  registered; high when count_bin == MAX_VAL
at_min  out  1  registered; high when count_bin == 0
wrap  out  1  registered one-cycle pulse on a wrap event (MAX->0 or 0->MAX)
sat_hit  out  1  registered one-cycle pulse when a step is blocked by saturation

Behaviour:
- One clock; reset is synchronous and active-low. All outputs update only on the rising edge of clk.
- Priority, per edge: rst_n==0 > load > en > hold.
- Reset values:
  - count_bin = RESET_VAL and count_gray = bin2gray(RESET_VAL).
  - at_max and at_min reflect RESET_VAL.
  - wrap = 0 and sat_hit = 0.
- Load: count_bin <= min(load_val, MAX_VAL). Out-of-range values clamp to MAX_VAL. wrap and sat_hit are 0. The en input is ignored that cycle.
- en=1, up_down=1:
  - If count_bin < MAX_VAL: count_bin + 1.
  - If count_bin == MAX_VAL and sat_mode=0: next is 0, wrap=1.
  - If count_bin == MAX_VAL and sat_mode=1: hold, sat_hit=1.
- en=1, up_down=0:
  - If count_bin > 0: count_bin - 1.
  - If count_bin == 0 and sat_mode=0: next is MAX_VAL, wrap=1.
  - If count_bin == 0 and sat_mode=1: hold, sat_hit=1.
- en=0 and load=0: hold all counts. wrap and sat_hit are 0 (pulses never stretch).
- Latency: count_gray, count_bin and flags are valid 1 cycle after the controlling edge. count_gray always equals bin2gray(count_bin); both come from the same register update.
- at_max and at_min are computed from the next-state value and registered, so they are never a cycle late. When MAX_VAL == 0 is disallowed, at_max and at_min are never both high.
- Gray property:
  - Every en-step changes exactly one bit of count_gray.
  - Exception: a wrap when MAX_VAL != 2**WIDTH-1 may change more than one bit. This is a documented limitation.
  - Loads may change any number of bits.
- up_down, sat_mode and en may change on any cycle. A direction change takes effect on the next edge, with no dead cycle.
- Reset asserted mid-count overrides load and en on that edge. Counting resumes from RESET_VAL on the first edge with rst_n=1.
- Arithmetic: binary next-state is computed in WIDTH bits. Bound comparisons use MAX_VAL cast to WIDTH bits; there is no reliance on natural overflow.
- No combinational path from any input to any output.

Decomposition:
- Package gray_cnt_pkg holds:
  - function bin2gray (xor of bin with bin>>1);
  - function gray2bin (prefix xor, used by the bench checker);
  - a localparam helper for the default MAX_VAL.
- One natural sub-module, gray_cnt_nextstate: combinational next binary value plus wrap/sat_hit/at_max/at_min decode.
- The top registers the results and the Gray conversion.

Test Plan:
1. Reset and up-count wrap: WIDTH=3, rst_n=0 for 1 clk, then en=1, up_down=1, sat_mode=0 for 9 clks.
   -> count_gray 000,001,011,010,110,111,101,100,000.
   -> wrap pulses exactly on the 100->000 edge; at_max high while 100 is shown.
2. Down-count wrap: from 000, up_down=0, en=1 for 2 clks.
   -> count_gray 100 (bin 7) with wrap=1, then 101 (bin 6); at_min low after the first step.
3. Saturate: sat_mode=1, load 7, then up for 3 clks.
   -> count_bin stays 7, sat_hit=1 on each blocked edge, wrap=0.
   -> Then up_down=0: next edge count_bin=6, sat_hit=0.
4. Load priority and clamp: WIDTH=3, MAX_VAL=5, load=1, en=1, load_val=7.
   -> count_bin=5, count_gray=111, at_max=1.
   -> Next up step with sat_mode=0 -> 0, wrap=1 (multi-bit Gray change allowed).
5. Reset mid-operation: RESET_VAL=3; count to 6, assert rst_n=0 together with load=1 and load_val=1.
   -> count_bin=3, count_gray=010, flags 0.
   -> Release: next en step -> 4 (gray 110).
6. Random soak: WIDTH=5, random en/up_down/load/sat_mode for 2000 clks.
   -> Reference model matches every cycle.
   -> count_gray==bin2gray(count_bin) on every cycle.
   -> Single-bit Gray change on every non-load, non-wrap step.

Source files
------------

// File: rtl/gray_cnt_pkg.sv
// ============================================================================
// gray_cnt_pkg : shared types and Gray conversion helpers for the counter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package gray_cnt_pkg;

  localparam int unsigned GC_W = 32;

  typedef enum logic [1:0] {
    GC_HOLD = 2'd0,
    GC_UP   = 2'd1,
    GC_DOWN = 2'd2,
    GC_LOAD = 2'd3
  } gc_op_e;

  typedef struct packed {
    logic at_max;
    logic at_min;
    logic wrap;
    logic sat_hit;
  } gc_flags_t;

  function automatic int unsigned gc_max_for(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [GC_W-1:0] bin2gray(input logic [GC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GC_W-1:0] gray2bin(input logic [GC_W-1:0] g);
    logic [GC_W-1:0] b;
    b[GC_W-1] = g[GC_W-1];
    for (int i = GC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_cnt_nextstate.sv
// ============================================================================
// gray_cnt_nextstate : next binary count plus boundary/event flag decode
// Revision           : 1.0
// ============================================================================
`default_nettype none

module gray_cnt_nextstate
  import gray_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MAX_VAL = gc_max_for(WIDTH)
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             en_i,
  input  logic             up_down_i,
  input  logic             sat_mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] nxt_o,
  output gc_flags_t        flags_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  gc_op_e           w_op;
  logic [WIDTH-1:0] w_load_clamped;

  // Clamp logic only exists when the range is narrower than the register.
  if (MAX_VAL < gc_max_for(WIDTH)) begin : g_clamp
    assign w_load_clamped = (load_val_i > MAX_W) ? MAX_W : load_val_i;
  end else begin : g_noclamp
    assign w_load_clamped = load_val_i;
  end

  always_comb begin
    if (load_i) begin
      w_op = GC_LOAD;
    end else if (!en_i) begin
      w_op = GC_HOLD;
    end else if (up_down_i) begin
      w_op = GC_UP;
    end else begin
      w_op = GC_DOWN;
    end
  end

  always_comb begin
    nxt_o           = cnt_i;
    flags_o.wrap    = 1'b0;
    flags_o.sat_hit = 1'b0;
    case (w_op)
      GC_LOAD: nxt_o = w_load_clamped;
      GC_UP: begin
        if (cnt_i < MAX_W) begin
          nxt_o = cnt_i + ONE_W;
        end else if (sat_mode_i) begin
          flags_o.sat_hit = 1'b1;
        end else begin
          nxt_o        = '0;
          flags_o.wrap = 1'b1;
        end
      end
      GC_DOWN: begin
        if (cnt_i != '0) begin
          nxt_o = cnt_i - ONE_W;
        end else if (sat_mode_i) begin
          flags_o.sat_hit = 1'b1;
        end else begin
          nxt_o        = MAX_W;
          flags_o.wrap = 1'b1;
        end
      end
      default: nxt_o = cnt_i;
    endcase
    flags_o.at_max = (nxt_o == MAX_W);
    flags_o.at_min = (nxt_o == '0);
  end

endmodule

`default_nettype wire

// File: rtl/gray_updown_counter_param.sv
// ============================================================================
// gray_updown_counter_param : Gray up/down counter with load, wrap/saturate
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module gray_updown_counter_param
  import gray_cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_VAL   = gc_max_for(WIDTH),
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_gray,
  output logic [WIDTH-1:0] count_bin,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(RESET_VAL));
  localparam logic             RST_MAX  = (RST_BIN == MAX_W);
  localparam logic             RST_MIN  = (RST_BIN == '0);

  logic [WIDTH-1:0] count_bin_d;
  logic [WIDTH-1:0] count_gray_d;
  gc_flags_t        flags_d;

  logic [WIDTH-1:0] count_bin_q;
  logic [WIDTH-1:0] count_gray_q;
  logic             at_max_q;
  logic             at_min_q;
  logic             wrap_q;
  logic             sat_hit_q;

  gray_cnt_nextstate #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_nextstate (
    .cnt_i      (count_bin_q),
    .en_i       (en),
    .up_down_i  (up_down),
    .sat_mode_i (sat_mode),
    .load_i     (load),
    .load_val_i (load_val),
    .nxt_o      (count_bin_d),
    .flags_o    (flags_d)
  );

  // Gray is derived from the next binary value so both registers agree.
  assign count_gray_d = WIDTH'(bin2gray(GC_W'(count_bin_d)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_bin_q  <= RST_BIN;
      count_gray_q <= RST_GRAY;
      at_max_q     <= RST_MAX;
      at_min_q     <= RST_MIN;
      wrap_q       <= 1'b0;
      sat_hit_q    <= 1'b0;
    end else begin
      count_bin_q  <= count_bin_d;
      count_gray_q <= count_gray_d;
      at_max_q     <= flags_d.at_max;
      at_min_q     <= flags_d.at_min;
      wrap_q       <= flags_d.wrap;
      sat_hit_q    <= flags_d.sat_hit;
    end
  end

  assign count_bin  = count_bin_q;
  assign count_gray = count_gray_q;
  assign at_max     = at_max_q;
  assign at_min     = at_min_q;
  assign wrap       = wrap_q;
  assign sat_hit    = sat_hit_q;

endmodule

`default_nettype wire
